// File: rtl/fighter_pkg.sv
// Shared types and constants for the fighter movement scheduler.
package fighter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_AIR      = 2'd1,
    ST_COOLDOWN = 2'd2
  } player_state_e;

  localparam int P0 = 0;
  localparam int P1 = 1;

  localparam int TICK_DIV_DEFAULT = 5_000_000;

  typedef struct packed {
    logic left;
    logic right;
    logic jump;
  } move_req_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running 0..DIV-1 counter; eval is high on the last count of each period.
import fighter_pkg::*;

module tick_divider #(
  parameter int DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic eval
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign eval = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (eval) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/fighter_move_scheduler.sv
// Per-tick movement/jump scheduler for two fighters with collision arbitration.
// Build option: STICKY_REQ_EN latches button presses between ticks.
import fighter_pkg::*;

module fighter_move_scheduler #(
  parameter int TICK_DIV       = TICK_DIV_DEFAULT,
  parameter int JUMP_TICKS     = 8,
  parameter int COOLDOWN_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_left,
  input  logic [1:0] btn_right,
  input  logic [1:0] btn_jump,
  input  logic       is_colliding,
  output logic       tick,
  output logic [1:0] cmd_left,
  output logic [1:0] cmd_right,
  output logic [1:0] cmd_jump,
  output logic [1:0] airborne,
  output logic       grant_last
);

  localparam int CW = $clog2(max2(JUMP_TICKS, COOLDOWN_TICKS) + 1);
  localparam logic [CW-1:0] JUMP_LOAD = CW'(JUMP_TICKS - 1);
  localparam logic [CW-1:0] CD_LOAD   = (COOLDOWN_TICKS > 0) ? CW'(COOLDOWN_TICKS - 1) : '0;

  logic            eval;
  move_req_t [1:0] req;
  logic [1:0]      mv_l, mv_r, jump_go;
  logic [1:0]      sup_l, sup_r;
  logic            clash;

  tick_divider #(.DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .eval  (eval)
  );

  for (genvar p = 0; p < 2; p++) begin : g_player
`ifdef STICKY_REQ_EN
    logic lat_l, lat_r, lat_j;
    // a press on the evaluation cycle itself is carried into the next period
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)    {lat_l, lat_r, lat_j} <= '0;
      else if (eval) {lat_l, lat_r, lat_j} <= {btn_left[p], btn_right[p], btn_jump[p]};
      else           {lat_l, lat_r, lat_j} <= {lat_l, lat_r, lat_j} |
                                              {btn_left[p], btn_right[p], btn_jump[p]};
    end
    assign req[p] = '{left: lat_l, right: lat_r, jump: lat_j};
`else
    assign req[p] = '{left: btn_left[p], right: btn_right[p], jump: btn_jump[p]};
`endif

    assign mv_l[p] = req[p].left  & ~req[p].right;
    assign mv_r[p] = req[p].right & ~req[p].left;

    player_state_e state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          go;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (eval) begin
        case (state)
          ST_IDLE: if (req[p].jump) begin
            state_nx = ST_AIR;
            cnt_nx   = JUMP_LOAD;
          end
          ST_AIR: if (cnt == '0) begin
            state_nx = (COOLDOWN_TICKS == 0) ? ST_IDLE : ST_COOLDOWN;
            cnt_nx   = CD_LOAD;
          end else cnt_nx = cnt - CW'(1);
          ST_COOLDOWN: if (cnt == '0) state_nx = ST_IDLE;
                       else           cnt_nx   = cnt - CW'(1);
          default: state_nx = ST_IDLE;
        endcase
      end
    end

    always_comb begin
      go = eval & (state == ST_IDLE) & req[p].jump;
    end

    assign jump_go[p]  = go;
    assign airborne[p] = (state == ST_AIR);
  end

  // Head-on pushes only: p0 right into p1 left. grant_last=1 means p0 wins next.
  assign clash = is_colliding & mv_r[P0] & mv_l[P1];

  always_comb begin
    sup_l = '0;
    sup_r = '0;
    if (clash) begin
      if (grant_last) sup_l[P1] = 1'b1;
      else            sup_r[P0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick       <= 1'b0;
      cmd_left   <= '0;
      cmd_right  <= '0;
      cmd_jump   <= '0;
      grant_last <= 1'b1;
    end else begin
      tick      <= eval;
      cmd_left  <= eval ? (mv_l & ~sup_l) : 2'b00;
      cmd_right <= eval ? (mv_r & ~sup_r) : 2'b00;
      cmd_jump  <= jump_go;
      if (eval && clash) grant_last <= ~grant_last;
    end
  end

endmodule

// File: tb/tb_fighter_move_scheduler.sv
// Directed + randomized bench for fighter_move_scheduler against a tick-level model.
module tb_fighter_move_scheduler;

  localparam int TD = 4;
  localparam int JT = 3;
  localparam int CT = 2;

  logic       clk, reset;
  logic [1:0] btn_left, btn_right, btn_jump;
  logic       is_colliding;
  logic       tick, grant_last;
  logic [1:0] cmd_left, cmd_right, cmd_jump, airborne;

  fighter_move_scheduler #(.TICK_DIV(TD), .JUMP_TICKS(JT), .COOLDOWN_TICKS(CT)) dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .is_colliding(is_colliding),
    .tick(tick), .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_jump(cmd_jump),
    .airborne(airborne), .grant_last(grant_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc, first_tick;

  // model state: phase within the period, pending presses, remaining air/cooldown ticks
  int        mcnt;
  bit  [1:0] pl, pr, pj;
  int        air[2], cd[2];
  bit        g;
  bit  [9:0] exp_v;

  function automatic logic [9:0] obs_v();
    return {tick, cmd_left, cmd_right, cmd_jump, airborne, grant_last};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mcnt = 0; pl = 0; pr = 0; pj = 0; g = 1'b1;
    for (int p = 0; p < 2; p++) begin air[p] = 0; cd[p] = 0; end
    exp_v = 10'b1;
  endfunction

  function automatic void model_edge();
    bit e;
    bit [1:0] rl, rr, rj, ml, mr, mj, ab;
    e = (mcnt == TD - 1);
    mcnt = (mcnt + 1) % TD;
    ml = 0; mr = 0; mj = 0;
    if (e) begin
`ifdef STICKY_REQ_EN
      rl = pl; rr = pr; rj = pj;
      pl = btn_left; pr = btn_right; pj = btn_jump;
`else
      rl = btn_left; rr = btn_right; rj = btn_jump;
`endif
      for (int p = 0; p < 2; p++) begin
        ml[p] = rl[p] && !rr[p];
        mr[p] = rr[p] && !rl[p];
        if (air[p] == 0 && cd[p] == 0) begin
          if (rj[p]) begin mj[p] = 1'b1; air[p] = JT; end
        end else if (air[p] > 0) begin
          air[p]--;
          if (air[p] == 0) cd[p] = CT;
        end else cd[p]--;
      end
      if (is_colliding && mr[0] && ml[1]) begin
        if (g) begin ml[1] = 1'b0; g = 1'b0; end
        else   begin mr[0] = 1'b0; g = 1'b1; end
      end
    end else begin
`ifdef STICKY_REQ_EN
      pl |= btn_left; pr |= btn_right; pj |= btn_jump;
`endif
    end
    for (int p = 0; p < 2; p++) ab[p] = (air[p] > 0);
    exp_v = {e, ml, mr, mj, ab, g};
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (tick === 1'b1 && first_tick < 0) first_tick = cyc;
    chk(tag, obs_v(), exp_v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 chk("reset_state", obs_v(), 10'b00000000_01);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    first_tick = -1;
  endtask

  task automatic drive(input logic [1:0] l, input logic [1:0] r, input logic [1:0] j,
                       input logic c);
    btn_left = l; btn_right = r; btn_jump = j; is_colliding = c;
  endtask

  initial begin
    bit seen, exp_pulse;
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    do_reset();

    // idle: tick cadence, no commands
    repeat (3 * TD) step("idle");
    chk("first_tick_cycle", 10'(first_tick), 10'(TD));

    // single-cycle right press for p0 in the middle of a period
    for (int i = 0; i < TD && mcnt != 1; i++) step("align");
    drive(2'b00, 2'b01, 2'b00, 1'b0);
    step("pulse");
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    seen = 1'b0;
    repeat (TD) begin step("pulse_wait"); seen |= cmd_right[0]; end
`ifdef STICKY_REQ_EN
    exp_pulse = 1'b1;
`else
    exp_pulse = 1'b0;
`endif
    chk("pulse_strobe", 10'(seen), 10'(exp_pulse));

    // p1 holds both directions
    drive(2'b10, 2'b10, 2'b00, 1'b0);
    repeat (3 * TD) step("conflict");

    // p0 holds jump through two full jump cycles
    drive(2'b00, 2'b00, 2'b01, 1'b0);
    repeat (10 * TD) step("jump");
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    repeat (8 * TD) step("jump_settle");

    // head-on collision, then p1 moving away
    drive(2'b10, 2'b01, 2'b00, 1'b1);
    repeat (3 * TD) step("collide");
    drive(2'b00, 2'b11, 2'b00, 1'b1);
    repeat (2 * TD) step("collide_away");

    // reset while p0 is airborne
    drive(2'b00, 2'b00, 2'b01, 1'b0);
    for (int i = 0; i < 3 * TD && airborne[0] !== 1'b1; i++) step("to_air");
    chk("airborne_before_reset", 10'(airborne[0]), 10'd1);
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    do_reset();
    repeat (3 * TD) step("post_reset");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive({($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)},
            {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)},
            {($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0)},
            ($urandom_range(0, 1) == 1));
      step("random");
    end
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    repeat (TD) step("drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
